// File: rtl/receiver.sv
// receiver: oversampled UART receiver with 2-flop rx synchronizer, LSB-first framing.
// Optional even-parity bit when RX_PARITY_EN is defined; default build has no parity.
module receiver #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  input  logic                  tick,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rx_done,
  output logic                  frame_err,
  output logic                  parity_err,
  output logic                  busy
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BLAST = BW'(DATA_WIDTH - 1);
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4, WAIT_HIGH = 3'd5;
`ifdef RX_PARITY_EN
  localparam logic [2:0] AFTER_DATA = PARITY;
`else
  localparam logic [2:0] AFTER_DATA = STOP;
`endif
  logic meta_q, rxs_q;
  logic [1:0] fill_q;
  logic armed_q, armed_d;
  logic [2:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d, dout_q, dout_d;
  logic done_q, done_d, ferr_q, ferr_d;
`ifdef RX_PARITY_EN
  logic perr_q, perr_d, plat_q, plat_d;
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif
  assign data_out = dout_q;
  assign rx_done = done_q;
  assign frame_err = ferr_q;
  assign busy = state_q != IDLE;
  // A line held low through reset must go high once before a start bit is accepted.
  assign armed_d = armed_q | (fill_q[1] & rxs_q);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    bit_d = bit_q;
    sh_d = sh_q;
    dout_d = dout_q;
    done_d = 1'b0;
    ferr_d = 1'b0;
`ifdef RX_PARITY_EN
    perr_d = 1'b0;
    plat_d = plat_q;
`endif
    case (state_q)
      IDLE: if (!rxs_q && armed_q) begin
        state_d = START;
        cnt_d = '0;
      end
      START: if (tick) begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == HALF) begin
          cnt_d = '0;
          bit_d = '0;
          state_d = rxs_q ? IDLE : DATA;
`ifdef RX_PARITY_EN
          plat_d = 1'b0;
`endif
        end
      end
      DATA: if (tick) begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          sh_d = {rxs_q, sh_q[DATA_WIDTH-1:1]};
          cnt_d = '0;
          bit_d = bit_q + 1'b1;
          state_d = bit_q == BLAST ? AFTER_DATA : DATA;
        end
      end
`ifdef RX_PARITY_EN
      PARITY: if (tick) begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          plat_d = rxs_q ^ (^sh_q);
          cnt_d = '0;
          state_d = STOP;
        end
      end
`endif
      STOP: if (tick) begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cnt_d = '0;
          dout_d = sh_q;
          ferr_d = !rxs_q;
          state_d = rxs_q ? IDLE : WAIT_HIGH;
`ifdef RX_PARITY_EN
          perr_d = plat_q;
          done_d = rxs_q && !plat_q;
`else
          done_d = rxs_q;
`endif
        end
      end
      WAIT_HIGH: state_d = rxs_q ? IDLE : WAIT_HIGH;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      rxs_q <= 1'b1;
      fill_q <= '0;
      armed_q <= 1'b0;
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      dout_q <= '0;
      done_q <= 1'b0;
      ferr_q <= 1'b0;
`ifdef RX_PARITY_EN
      perr_q <= 1'b0;
      plat_q <= 1'b0;
`endif
    end else begin
      meta_q <= rx;
      rxs_q <= meta_q;
      fill_q <= {fill_q[0], 1'b1};
      armed_q <= armed_d;
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      dout_q <= dout_d;
      done_q <= done_d;
      ferr_q <= ferr_d;
`ifdef RX_PARITY_EN
      perr_q <= perr_d;
      plat_q <= plat_d;
`endif
    end
  end
endmodule

// File: tb/tb_receiver.sv
// tb_receiver: directed vector table plus hand sequences for glitch, break, reset and back-to-back frames.
module tb_receiver;
  localparam int OS = 16;
  logic clk = 1'b0, rst = 1'b1, rx = 1'b1, tick = 1'b0;
  logic [7:0] data_out;
  logic rx_done, frame_err, parity_err, busy;
  int div = 1, ph = 0, checks = 0, errors = 0;
  int done_n = 0, ferr_n = 0, perr_n = 0, busy_n = 0, ovl_n = 0;
  int d0, f0, p0, b0;
`ifdef RX_PARITY_EN
  logic pflip = 1'b0;
`endif
  receiver #(.DATA_WIDTH(8), .OVERSAMPLE(OS)) dut (
    .clk(clk), .rst(rst), .rx(rx), .tick(tick), .data_out(data_out),
    .rx_done(rx_done), .frame_err(frame_err), .parity_err(parity_err), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    done_n += int'(rx_done);
    ferr_n += int'(frame_err);
    perr_n += int'(parity_err);
    busy_n += int'(busy);
    ovl_n += int'(rx_done & (frame_err | parity_err));
  end
  typedef struct {
    logic [7:0] d;
    logic stop;
    int dv;
    int hold;
    int exp_done;
    int exp_ferr;
    int exp_busy;
  } vec_t;
  vec_t vecs[6];
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
    ph = (ph + 1 >= div) ? 0 : ph + 1;
    tick = (ph == 0);
  endtask
  task automatic bit_per(input logic b);
    rx = b;
    repeat (OS * div) cyc();
  endtask
  task automatic send(input logic [7:0] d, input logic stop);
    bit_per(1'b0);
    for (int i = 0; i < 8; i++) bit_per(d[i]);
`ifdef RX_PARITY_EN
    bit_per((^d) ^ pflip);
`endif
    bit_per(stop);
  endtask
  task automatic snap();
    d0 = done_n;
    f0 = ferr_n;
    p0 = perr_n;
    b0 = busy_n;
  endtask
  initial begin
    vecs[0] = '{8'h55, 1'b1, 1, 0, 1, 0, 152};
    vecs[1] = '{8'hA3, 1'b0, 1, 40, 0, 1, -1};
    vecs[2] = '{8'h3C, 1'b1, 1, 0, 1, 0, 152};
    vecs[3] = '{8'h81, 1'b1, 2, 0, 1, 0, 304};
    vecs[4] = '{8'h00, 1'b1, 3, 0, 1, 0, -1};
    vecs[5] = '{8'h6E, 1'b0, 3, 5, 0, 1, -1};
    repeat (3) cyc();
    chk("reset data_out", int'(data_out), 0);
    chk("reset rx_done", int'(rx_done), 0);
    chk("reset frame_err", int'(frame_err), 0);
    chk("reset parity_err", int'(parity_err), 0);
    chk("reset busy", int'(busy), 0);
    rst = 1'b0;
    repeat (6) cyc();
    foreach (vecs[k]) begin
      div = vecs[k].dv;
      ph = 0;
      snap();
      send(vecs[k].d, vecs[k].stop);
      repeat (vecs[k].hold * div) cyc();
      rx = 1'b1;
      repeat (2 * OS * div) cyc();
      chk($sformatf("vec%0d rx_done", k), done_n - d0, vecs[k].exp_done);
      chk($sformatf("vec%0d frame_err", k), ferr_n - f0, vecs[k].exp_ferr);
      chk($sformatf("vec%0d parity_err", k), perr_n - p0, 0);
      chk($sformatf("vec%0d data_out", k), int'(data_out), int'(vecs[k].d));
      chk($sformatf("vec%0d busy idle", k), int'(busy), 0);
      if (vecs[k].exp_busy >= 0) chk($sformatf("vec%0d busy cycles", k), busy_n - b0, vecs[k].exp_busy);
    end
    div = 1;
    ph = 0;
    snap();
    rx = 1'b0;
    repeat (5) cyc();
    rx = 1'b1;
    repeat (3 * OS) cyc();
    chk("glitch rx_done", done_n - d0, 0);
    chk("glitch frame_err", ferr_n - f0, 0);
    chk("glitch data_out", int'(data_out), 8'h6E);
    chk("glitch busy", int'(busy), 0);
    snap();
    send(8'hA3, 1'b0);
    repeat (40) cyc();
    chk("break still busy", int'(busy), 1);
    chk("break frame_err", ferr_n - f0, 1);
    chk("break rx_done", done_n - d0, 0);
    chk("break data_out", int'(data_out), 8'hA3);
    repeat (3 * OS) cyc();
    chk("break no restart", done_n - d0, 0);
    rx = 1'b1;
    repeat (OS) cyc();
    chk("break idle after high", int'(busy), 0);
    send(8'h5A, 1'b1);
    rx = 1'b1;
    repeat (2 * OS) cyc();
    chk("after break rx_done", done_n - d0, 1);
    chk("after break data_out", int'(data_out), 8'h5A);
    snap();
    bit_per(1'b0);
    for (int i = 0; i < 4; i++) bit_per(1'b1);
    rx = 1'b1;
    repeat (8) cyc();
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
    chk("rst data_out", int'(data_out), 0);
    chk("rst busy", int'(busy), 0);
    repeat (6 * OS) cyc();
    chk("aborted rx_done", done_n - d0, 0);
    chk("aborted frame_err", ferr_n - f0, 0);
    send(8'h3C, 1'b1);
    rx = 1'b1;
    repeat (2 * OS) cyc();
    chk("post rst rx_done", done_n - d0, 1);
    chk("post rst data_out", int'(data_out), 8'h3C);
    div = 3;
    ph = 0;
    snap();
    send(8'h00, 1'b1);
    chk("b2b first rx_done", done_n - d0, 1);
    chk("b2b first data_out", int'(data_out), 8'h00);
    send(8'hFF, 1'b1);
    rx = 1'b1;
    repeat (2 * OS * div) cyc();
    chk("b2b second rx_done", done_n - d0, 2);
    chk("b2b second data_out", int'(data_out), 8'hFF);
    chk("b2b frame_err", ferr_n - f0, 0);
`ifdef RX_PARITY_EN
    div = 1;
    ph = 0;
    snap();
    pflip = 1'b1;
    send(8'h07, 1'b1);
    rx = 1'b1;
    repeat (2 * OS) cyc();
    chk("bad parity parity_err", perr_n - p0, 1);
    chk("bad parity rx_done", done_n - d0, 0);
    chk("bad parity data_out", int'(data_out), 8'h07);
    snap();
    pflip = 1'b0;
    send(8'h07, 1'b1);
    rx = 1'b1;
    repeat (2 * OS) cyc();
    chk("good parity rx_done", done_n - d0, 1);
    chk("good parity parity_err", perr_n - p0, 0);
`endif
    chk("pulse overlap", ovl_n, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
